avr_spi_mstr_xfer_ctrl: RTL and testbench

//  Master-mode transfer sequencer for the AVR-compatible SPI core, in the core clock domain.

---
 rtl/avr_spi_mstr_xfer_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_avr_spi_mstr_xfer_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_spi_mstr_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// avr_spi_mstr_xfer_ctrl
//
// Master-mode transfer sequencer of the AVR-compatible SPI core (core clock
// domain). A byte written to SPDR is shifted out on MOSI while MISO is shifted
// in. SCK is generated at the SPR/SPI2X rate with CPOL/CPHA timing. The block
// raises SPIF/WCOL/MODF set pulses for the status register logic. It is inert
// unless SPE=1 and MSTR=1; slave transfers live in the SCK-domain logic.
//
// Timing reference: the clock edge that accepts a write starts "cycle 0" of
// the transfer (first cycle with busy=1). SCK edge k (k=1..2*DATA_W) becomes
// visible in cycle k*H, and the one-cycle DONE state (spif_set) is cycle
// 2*DATA_W*H+1.
//
// Ports
//   clk       in   core clock
//   rst       in   asynchronous active-high reset
//   spe       in   SPCR.SPE
//   mstr      in   SPCR.MSTR
//   cpol      in   SPCR.CPOL, SCK idle level
//   cpha      in   SPCR.CPHA, 0 = sample on leading edge, 1 = on trailing edge
//   dord      in   SPCR.DORD, 1 = LSB first
//   spr       in   SPCR.SPR[1:0]
//   spi2x     in   SPSR.SPI2X
//   wr_stb    in   one-cycle SPDR write strobe
//   wr_data   in   byte to send
//   ss_b_i    in   synchronised SS pin; low while master is a mode fault
//   miso_i    in   synchronised MISO pin
//   sck_o     out  SCK pin drive
//   mosi_o    out  MOSI pin drive
//   busy      out  transfer in progress
//   rx_data   out  received byte, valid from the spif_set cycle onward
//   spif_set  out  one-cycle pulse: transfer complete
//   wcol_set  out  one-cycle pulse: write collision
//   modf_set  out  one-cycle pulse: mode fault
// ---------------------------------------------------------------------------
module avr_spi_mstr_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int HCNT_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spe,
    input  logic              mstr,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              dord,
    input  logic [1:0]        spr,
    input  logic              spi2x,
    input  logic              wr_stb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ss_b_i,
    input  logic              miso_i,
    output logic              sck_o,
    output logic              mosi_o,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              spif_set,
    output logic              wcol_set,
    output logic              modf_set
);

    // Edge counter must hold 0..2*DATA_W inclusive.
    localparam int ECNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [ECNT_W-1:0] ECNT_ALL  = ECNT_W'(2 * DATA_W);
    // The last odd-numbered completed count: the edge after it is the final one.
    localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [HCNT_W-1:0]   hcnt_reg;     // core clocks elapsed in current half period
    logic [HCNT_W-1:0]   hlim_reg;     // half period minus one, latched at accept
    logic [ECNT_W-1:0]   ecnt_reg;     // SCK edges already generated
    logic [DATA_W-1:0]   tx_sr_reg;    // bits still to be driven
    logic [DATA_W-1:0]   rx_sr_reg;    // bits sampled so far
    logic                sck_reg;
    logic                mosi_reg;
    logic [DATA_W-1:0]   rx_data_reg;
    logic                wcol_reg;
    logic                modf_reg;

    logic                run_ok;
    logic                mode_fault;
    logic                accept;
    logic                half_done;
    logic                all_edges;
    logic                sck_edge;
    logic                next_edge_odd;
    logic                sample_stb;
    logic                drive_stb;

    // Half period minus one, indexed by {spi2x, spr}. H = D/2 with
    // D = 4,16,64,128 (spi2x=0) or 2,8,32,64 (spi2x=1).
    function automatic logic [HCNT_W-1:0] half_m1(input logic [2:0] sel);
        logic [HCNT_W-1:0] r;
        case (sel)
            3'b000:  r = HCNT_W'(1);
            3'b001:  r = HCNT_W'(7);
            3'b010:  r = HCNT_W'(31);
            3'b011:  r = HCNT_W'(63);
            3'b100:  r = HCNT_W'(0);
            3'b101:  r = HCNT_W'(3);
            3'b110:  r = HCNT_W'(15);
            default: r = HCNT_W'(31);
        endcase
        return r;
    endfunction

    // Bit that goes on the wire next.
    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb_first);
        return lsb_first ? v[0] : v[DATA_W-1];
    endfunction

    // Discard the bit just driven.
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v,
                                                   input logic lsb_first);
        return lsb_first ? (v >> 1) : (v << 1);
    endfunction

    // Insert a sampled bit so the first bit received lands in the first-bit position.
    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] v,
                                                    input logic b,
                                                    input logic lsb_first);
        return lsb_first ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    always_comb begin
        run_ok        = spe & mstr & ss_b_i;
        mode_fault    = spe & mstr & ~ss_b_i;
        // DONE counts as not busy, so a write there starts the next byte.
        accept        = wr_stb & run_ok & (state_reg != ST_SHIFT);
        half_done     = (hcnt_reg == hlim_reg);
        all_edges     = (ecnt_reg == ECNT_ALL);
        sck_edge      = (state_reg == ST_SHIFT) & run_ok & ~all_edges & half_done;
        // ecnt_reg counts completed edges, so the edge about to happen is
        // odd when ecnt_reg is even.
        next_edge_odd = ~ecnt_reg[0];
        sample_stb    = sck_edge & (cpha ? ~next_edge_odd : next_edge_odd);
        // cpha=0 drives the first bit at accept, then on even edges except the
        // final one; cpha=1 drives on every odd edge.
        drive_stb     = sck_edge & (cpha ? next_edge_odd
                                         : (~next_edge_odd & (ecnt_reg != ECNT_LAST)));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Loss of SPE/MSTR or a mode fault aborts silently to IDLE.
                if (!run_ok) begin
                    state_next = ST_IDLE;
                end else if (all_edges) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = accept ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_reg    <= '0;
            hlim_reg    <= '0;
            ecnt_reg    <= '0;
            tx_sr_reg   <= '0;
            rx_sr_reg   <= '0;
            sck_reg     <= 1'b0;
            mosi_reg    <= 1'b0;
            rx_data_reg <= '0;
            wcol_reg    <= 1'b0;
            modf_reg    <= 1'b0;
        end else begin
            // Collision only for a write that would otherwise be legal.
            wcol_reg <= wr_stb & run_ok & (state_reg == ST_SHIFT);
            modf_reg <= mode_fault;

            if (accept) begin
                hlim_reg  <= half_m1({spi2x, spr});
                hcnt_reg  <= '0;
                ecnt_reg  <= '0;
                rx_sr_reg <= '0;
                sck_reg   <= cpol;
                if (!cpha) begin
                    mosi_reg  <= first_bit(wr_data, dord);
                    tx_sr_reg <= tx_shift(wr_data, dord);
                end else begin
                    tx_sr_reg <= wr_data;
                end
            end else if ((state_reg == ST_SHIFT) && run_ok) begin
                if (!all_edges) begin
                    if (half_done) begin
                        hcnt_reg <= '0;
                        ecnt_reg <= ecnt_reg + 1'b1;
                        sck_reg  <= ~sck_reg;
                    end else begin
                        hcnt_reg <= hcnt_reg + 1'b1;
                    end
                end
                if (sample_stb) begin
                    rx_sr_reg <= rx_insert(rx_sr_reg, miso_i, dord);
                end
                if (drive_stb) begin
                    mosi_reg  <= first_bit(tx_sr_reg, dord);
                    tx_sr_reg <= tx_shift(tx_sr_reg, dord);
                end
                // Published on entry to DONE so it is valid with spif_set.
                if (all_edges) begin
                    rx_data_reg <= rx_sr_reg;
                end
            end else begin
                // Idle, DONE or abort: SCK parks at CPOL; MOSI holds its last bit.
                sck_reg <= cpol;
            end
        end
    end

    assign sck_o    = sck_reg;
    assign mosi_o   = mosi_reg;
    assign busy     = (state_reg == ST_SHIFT);
    assign rx_data  = rx_data_reg;
    assign spif_set = (state_reg == ST_DONE);
    assign wcol_set = wcol_reg;
    assign modf_set = modf_reg;

endmodule

// File: tb/tb_avr_spi_mstr_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_avr_spi_mstr_xfer_ctrl
//
// Directed bench for the SPI master sequencer. A transaction-level model
// predicts every output each cycle from the protocol rules (cycle index since
// accept, half period, edge numbering); a negedge compare process checks the
// DUT against it. Directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_avr_spi_mstr_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spe = 1'b0;
    logic       mstr = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       dord = 1'b0;
    logic [1:0] spr = 2'b00;
    logic       spi2x = 1'b0;
    logic       wr_stb = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ss_b_i = 1'b1;
    logic       miso_i;
    logic       miso_loop = 1'b0;
    logic       miso_fix = 1'b0;
    logic       sck_o, mosi_o, busy, spif_set, wcol_set, modf_set;
    logic [7:0] rx_data;

    assign miso_i = miso_loop ? mosi_o : miso_fix;

    always #5 clk = ~clk;

    avr_spi_mstr_xfer_ctrl #(.DATA_W(8), .HCNT_W(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .spe      (spe),
        .mstr     (mstr),
        .cpol     (cpol),
        .cpha     (cpha),
        .dord     (dord),
        .spr      (spr),
        .spi2x    (spi2x),
        .wr_stb   (wr_stb),
        .wr_data  (wr_data),
        .ss_b_i   (ss_b_i),
        .miso_i   (miso_i),
        .sck_o    (sck_o),
        .mosi_o   (mosi_o),
        .busy     (busy),
        .rx_data  (rx_data),
        .spif_set (spif_set),
        .wcol_set (wcol_set),
        .modf_set (modf_set)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int spif_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Clock divider D from {spi2x, spr}.
    function automatic int div_of(input logic [2:0] sel);
        case (sel)
            3'd0: return 4;
            3'd1: return 16;
            3'd2: return 64;
            3'd3: return 128;
            3'd4: return 2;
            3'd5: return 8;
            3'd6: return 32;
            default: return 64;
        endcase
    endfunction

    // i-th bit put on the wire for byte d.
    function automatic logic tx_bit(input logic [7:0] d, input logic lsb_first, input int i);
        return lsb_first ? d[i] : d[7-i];
    endfunction

    // ------------------------------------------------------------------
    // Reference model: expected outputs for the cycle after each clock edge
    // ------------------------------------------------------------------
    logic       m_busy, m_sck, m_mosi, m_spif, m_wcol, m_modf;
    logic [7:0] m_rx, m_data;
    logic       m_cpol, m_cpha, m_dord;
    int         m_t, m_h, m_ns;
    logic       samp [8];
    logic       m_ok;
    int         m_k, m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_sck = 1'b0; m_mosi = 1'b0; m_spif = 1'b0;
            m_wcol = 1'b0; m_modf = 1'b0; m_rx = 8'h00; m_data = 8'h00;
            m_t = 0; m_h = 1; m_ns = 0;
            m_cpol = 1'b0; m_cpha = 1'b0; m_dord = 1'b0;
        end else begin
            m_ok   = spe & mstr & ss_b_i;
            m_wcol = wr_stb & m_busy & m_ok;
            m_modf = spe & mstr & ~ss_b_i;
            m_spif = 1'b0;
            if (m_busy && m_ok) begin
                // An edge lands in cycle k*H; it samples MISO as seen just before it.
                if ((m_t + 1) % m_h == 0) begin
                    m_k = (m_t + 1) / m_h;
                    if (m_k <= 16 && ((m_k % 2 == 1) != m_cpha) && m_ns < 8) begin
                        samp[m_ns] = miso_i;
                        m_ns++;
                    end
                end
                m_t++;
                if (m_t == 16 * m_h + 1) begin
                    m_busy = 1'b0;
                    m_spif = 1'b1;
                    for (int j = 0; j < 8; j++) begin
                        if (m_dord) m_rx[j] = samp[j];
                        else        m_rx[7-j] = samp[j];
                    end
                end else begin
                    m_k = m_t / m_h;
                    if (m_k > 16) m_k = 16;
                    m_sck = m_cpol ^ m_k[0];
                    if (!m_cpha) m_idx = m_t / (2 * m_h);
                    else         m_idx = (m_t >= m_h) ? (m_t - m_h) / (2 * m_h) : -1;
                    if (m_idx > 7) m_idx = 7;
                    if (m_idx >= 0) m_mosi = tx_bit(m_data, m_dord, m_idx);
                end
            end else begin
                m_busy = 1'b0;
                m_sck  = cpol;
                if (wr_stb && m_ok) begin
                    m_busy = 1'b1;
                    m_t    = 0;
                    m_ns   = 0;
                    m_h    = div_of({spi2x, spr}) / 2;
                    m_data = wr_data;
                    m_cpol = cpol;
                    m_cpha = cpha;
                    m_dord = dord;
                    if (!cpha) m_mosi = tx_bit(wr_data, dord, 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("busy",     busy,     m_busy);
            check("sck_o",    sck_o,    m_sck);
            check("mosi_o",   mosi_o,   m_mosi);
            check("rx_data",  rx_data,  m_rx);
            check("spif_set", spif_set, m_spif);
            check("wcol_set", wcol_set, m_wcol);
            check("modf_set", modf_set, m_modf);
            if (spif_set) spif_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (callers sit 1 ns after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic p, input logic ph, input logic d, input logic [2:0] sel);
        spe = 1'b1; mstr = 1'b1; cpol = p; cpha = ph; dord = d;
        {spi2x, spr} = sel;
        tick(3);
    endtask

    task automatic start_write(input logic [7:0] d);
        wr_data = d;
        wr_stb  = 1'b1;
        tick(1);
        wr_stb  = 1'b0;
    endtask

    // Wait (bounded) for spif_set; capture MOSI at each bit's first visible cycle.
    // Returns at the negedge of the spif cycle, st = its cycle index or -1.
    task automatic wait_spif(input int t0, input int h, input logic cph,
                             output int st, output logic [7:0] mb);
        int t;
        t  = t0;
        st = -1;
        mb = 8'h00;
        while (t < t0 + 400) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if ((!cph && t == 2 * i * h) || (cph && t == (2 * i + 1) * h))
                    mb[7-i] = mosi_o;
            end
            if (spif_set) begin
                st = t;
                break;
            end
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    int         st;
    int         cnt0;
    logic [7:0] mb;

    initial begin
        // Reset state
        tick(2);
        @(negedge clk);
        check("rst_sck", sck_o, 0);
        check("rst_mosi", mosi_o, 0);
        check("rst_busy", busy, 0);
        check("rst_rx", rx_data, 0);
        check("rst_flags", {spif_set, wcol_set, modf_set}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // 1: H=1 mode 0, loopback 0xA5
        miso_loop = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 3'b100);
        start_write(8'hA5);
        wait_spif(0, 1, 1'b0, st, mb);
        check("t1_spif_cycle", st, 17);
        check("t1_mosi_bits", mb, 8'hA5);
        check("t1_rx", rx_data, 8'hA5);
        $display("[TB] xfer1 tx=a5 spif@%0d rx=%0h", st, rx_data);
        tick(3);

        // 2: cpol=1 cpha=1 LSB first, H=8, MISO tied high
        miso_loop = 1'b0;
        miso_fix  = 1'b1;
        set_cfg(1'b1, 1'b1, 1'b1, 3'b001);
        check("t2_sck_idle", sck_o, 1);
        start_write(8'h3C);
        wait_spif(0, 8, 1'b1, st, mb);
        check("t2_spif_cycle", st, 129);
        check("t2_mosi_bits", mb, 8'b0011_1100);
        check("t2_rx", rx_data, 8'hFF);
        $display("[TB] xfer2 tx=3c spif@%0d rx=%0h", st, rx_data);
        tick(3);

        // 3: write collision at cycle 5 of an H=2 transfer
        miso_loop = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 3'b000);
        cnt0 = spif_cnt;
        start_write(8'h5A);
        tick(5);
        wr_data = 8'hC3;
        wr_stb  = 1'b1;
        tick(1);
        wr_stb  = 1'b0;
        @(negedge clk);
        check("t3_wcol", wcol_set, 1);
        @(posedge clk);
        #1;
        wait_spif(7, 2, 1'b0, st, mb);
        check("t3_spif_cycle", st, 33);
        check("t3_rx", rx_data, 8'h5A);
        tick(50);
        check("t3_no_second", spif_cnt - cnt0, 1);
        $display("[TB] xfer3 tx=5a collided spif@%0d rx=%0h", st, rx_data);

        // 4: back-to-back write in the DONE cycle
        set_cfg(1'b0, 1'b0, 1'b0, 3'b100);
        cnt0 = spif_cnt;
        start_write(8'h96);
        tick(17);
        wr_data = 8'h69;
        wr_stb  = 1'b1;
        @(negedge clk);
        check("t4_spif_first", spif_set, 1);
        @(posedge clk);
        #1;
        wr_stb = 1'b0;
        @(negedge clk);
        check("t4_no_wcol", wcol_set, 0);
        check("t4_busy2", busy, 1);
        check("t4_sck_c0", sck_o, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_sck_c1", sck_o, 1);
        @(posedge clk);
        #1;
        wait_spif(2, 1, 1'b0, st, mb);
        check("t4_spif_cycle", st, 17);
        check("t4_rx", rx_data, 8'h69);
        tick(2);
        check("t4_spif_count", spif_cnt - cnt0, 2);
        $display("[TB] xfer4 back-to-back 96/69 spif@%0d rx=%0h", st, rx_data);

        // 5a: mode fault at edge 6 (H=2 -> cycle 12)
        set_cfg(1'b1, 1'b0, 1'b0, 3'b000);
        cnt0 = spif_cnt;
        start_write(8'h33);
        tick(12);
        ss_b_i = 1'b0;
        tick(1);
        ss_b_i = 1'b1;
        @(negedge clk);
        check("t5_modf", modf_set, 1);
        check("t5_busy", busy, 0);
        check("t5_sck", sck_o, 1);
        check("t5_rx_kept", rx_data, 8'h69);
        tick(60);
        check("t5_no_spif", spif_cnt - cnt0, 0);
        $display("[TB] xfer5 modf abort rx=%0h", rx_data);

        // 5b: SPE dropped at edge 6
        start_write(8'h33);
        tick(12);
        spe = 1'b0;
        tick(1);
        spe = 1'b1;
        @(negedge clk);
        check("t5b_modf", modf_set, 0);
        check("t5b_busy", busy, 0);
        check("t5b_sck", sck_o, 1);
        check("t5b_rx_kept", rx_data, 8'h69);
        tick(60);
        check("t5b_no_spif", spif_cnt - cnt0, 0);
        $display("[TB] xfer5b spe abort rx=%0h", rx_data);

        // 6: asynchronous reset mid-transfer, then a clean transfer
        set_cfg(1'b1, 1'b0, 1'b0, 3'b100);
        start_write(8'hF0);
        tick(7);
        #2;
        rst = 1'b1;
        #1;
        check("t6_sck", sck_o, 0);
        check("t6_mosi", mosi_o, 0);
        check("t6_busy", busy, 0);
        check("t6_rx", rx_data, 0);
        check("t6_flags", {spif_set, wcol_set, modf_set}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
        check("t6_sck_cpol", sck_o, 1);
        start_write(8'h81);
        wait_spif(0, 1, 1'b0, st, mb);
        check("t6_spif_cycle", st, 17);
        check("t6_mosi_bits", mb, 8'h81);
        check("t6_rx", rx_data, 8'h81);
        $display("[TB] xfer6 after reset tx=81 spif@%0d rx=%0h", st, rx_data);
        tick(3);

        // 7: cpha=1 MSB first, H=4, loopback
        set_cfg(1'b0, 1'b1, 1'b0, 3'b101);
        start_write(8'h4E);
        wait_spif(0, 4, 1'b1, st, mb);
        check("t7_spif_cycle", st, 65);
        check("t7_mosi_bits", mb, 8'h4E);
        check("t7_rx", rx_data, 8'h4E);
        $display("[TB] xfer7 tx=4e spif@%0d rx=%0h", st, rx_data);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
